// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx parallel-in serial-out transmitter.
// Holds the FSM state encoding, gap counter width and a counter-width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } piso_state_e;

    // GAP_CYCLES is limited to 0..15.
    localparam int unsigned GAP_CW = 4;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter feeding a sipo stage through dout/load.
// Define PISO_PARITY_EN to append an even-parity bit after each data word.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             load,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CW = clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST =
        GAP_CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    piso_state_e       r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_shift, w_shift_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [GAP_CW-1:0] r_gap, w_gap_nxt;
    logic              r_dout, w_dout_nxt;
    logic              r_load, w_load_nxt;
    logic              w_last, w_ready, w_accept, w_bit;
`ifdef PISO_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_dout  <= 1'b0;
            r_load  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_dout  <= w_dout_nxt;
            r_load  <= w_load_nxt;
`ifdef PISO_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_dout_nxt  = r_dout;
        w_load_nxt  = r_load;
`ifdef PISO_PARITY_EN
        w_par_nxt   = r_par;
`endif

        w_last = (r_state == StShift) && (r_cnt == CNT_LAST);
        // Without a gap, the last-bit cycle also accepts so words stream with no bubble.
        w_ready = rst_n && ((r_state == StIdle) || ((GAP_CYCLES == 0) && w_last));
        w_accept = din_valid && w_ready;

        w_bit = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
`ifdef PISO_PARITY_EN
        if (r_cnt == CW'(WIDTH - 1)) begin
            w_bit = r_par;
        end
`endif

        if (w_accept) begin
            w_state_nxt = StShift;
            w_cnt_nxt   = '0;
            w_load_nxt  = 1'b1;
            w_dout_nxt  = MSB_FIRST ? din[WIDTH-1] : din[0];
            w_shift_nxt = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
`ifdef PISO_PARITY_EN
            w_par_nxt   = ^din;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_dout_nxt = 1'b0;
                    w_load_nxt = 1'b0;
                end
                StShift: begin
                    if (w_last) begin
                        w_state_nxt = (GAP_CYCLES != 0) ? StGap : StIdle;
                        w_cnt_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_dout_nxt  = 1'b0;
                        w_load_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CW'(1);
                        w_dout_nxt  = w_bit;
                        w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                                : {1'b0, r_shift[WIDTH-1:1]};
                    end
                end
                StGap: begin
                    w_dout_nxt = 1'b0;
                    w_load_nxt = 1'b0;
                    if (r_gap == GAP_LAST) begin
                        w_state_nxt = StIdle;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + GAP_CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_dout_nxt  = 1'b0;
                    w_load_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign din_ready = w_ready;
    assign dout      = r_dout;
    assign load      = r_load;
    assign busy      = (r_state != StIdle);

endmodule
